ic_fetch_aligner: RTL and testbench
===================================

Name: ic_fetch_aligner

Overview:
- Fetch stage directly upstream of the RV32IC decompressor in the single-cycle core.
- Issues word-aligned reads to instruction memory and keeps a 3-halfword alignment buffer.
- Each cycle it presents one complete instruction, 16-bit or 32-bit, starting at any halfword address, with its PC.
- Compressed instructions go out zero-extended in inst_o[15:0], so inst_o[1:0]!=2'b11 identifies them to the decompressor.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 must be 0.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- imem_req, output, 1, read request; the memory always accepts it in the same cycle.
- imem_addr, output, 32, word-aligned read address; bits [1:0] are always 00.
- imem_rdata, input, 32, read data; bits [15:0] are the lower-address halfword.
- imem_rvalid, input, 1, imem_rdata is valid this cycle; latency is 1 or more cycles; at most one request is outstanding.
- redirect, input, 1, branch/jump taken; flush and restart at redirect_pc.
- redirect_pc, input, 32, new PC; halfword-aligned, bit 0 is ignored.
- inst_o, output, 32, instruction to the decompressor.
- inst_pc, output, 32, address of inst_o.
- inst_valid, output, 1, inst_o/inst_pc are valid.
- inst_ready, input, 1, downstream accepts; fire = inst_valid & inst_ready & !redirect.

Behaviour:
- State:
  - buf[47:0] holds 3 halfwords; hw0 (buf[15:0]) is the oldest.
  - cnt holds 0..3 halfwords.
  - pc is the address of hw0.
  - faddr is the next fetch word address.
  - drop_lo is 1 bit.
  - FSM is one of S_FETCH, S_WAIT, S_DISCARD.
- Reset values (async):
  - cnt=0, buf=0, pc=RESET_PC, faddr={RESET_PC[31:2],2'b00}, drop_lo=RESET_PC[1], state=S_FETCH.
  - Outputs: imem_req=0 (combinational from reset state at rst_n release), inst_valid=0, inst_o=0, inst_pc=RESET_PC.
- Output assembly (combinational from registers):
  - Compressed: if cnt>=1 and hw0[1:0]!=11, then inst_o={16'h0,hw0} and inst_valid=1.
  - 32-bit: if hw0[1:0]==11 and cnt>=2, then inst_o={hw1,hw0} and inst_valid=1.
  - Otherwise inst_valid=0 and inst_o=0. inst_pc=pc always.
- Consume on fire:
  - cnt decreases by 1 (compressed) or 2 (32-bit); buf shifts down by the same amount.
  - pc advances by 2 or 4, with 32-bit wrap-around.
- imem_req = (state==S_FETCH) & (cnt_after_consume<=1) & !redirect; imem_addr=faddr. On a request, state goes to S_WAIT.
- S_WAIT, imem_rvalid & !redirect:
  - Append imem_rdata halfwords at position cnt_after_consume.
  - If drop_lo=1, append only rdata[31:16] and clear drop_lo.
  - faddr += 4; state goes to S_FETCH.
  - Consume and append in the same cycle are legal; the append goes after the consumed halfwords are removed.
  - cnt never exceeds 3.
- Redirect, which has highest priority in every state:
  - cnt=0, pc={redirect_pc[31:1],1'b0}, faddr={redirect_pc[31:2],2'b00}, drop_lo=redirect_pc[1].
  - No fire and no request that cycle.
- Next state on redirect:
  - S_FETCH goes to S_FETCH.
  - S_WAIT with imem_rvalid that cycle goes to S_FETCH; the data is discarded.
  - S_WAIT without imem_rvalid goes to S_DISCARD.
  - S_DISCARD stays in S_DISCARD.
- S_DISCARD, imem_rvalid: drop the data and go to S_FETCH; the new request goes out the following cycle.
- A 32-bit instruction whose upper half is in the next word: inst_valid stays 0 until that word arrives.
- When the downstream stalls (inst_ready=0), buffer contents and outputs hold and no request is issued while cnt>=2.
- Reset mid-fetch: the pending response is not tracked. The memory side is required to reset together with this block.

Test Plan:
- Reset, RESET_PC=0; mem[0]=32'h0041_0113 (addi); 1-cycle latency; inst_ready=1 -> imem_req at the first cycle with addr 0. Next cycle: inst_valid=1, inst_o=32'h0041_0113, inst_pc=0; then the request for addr 4.
- mem[0]={16'h4505 (c.li), 16'h0505 (c.addi)} -> two consecutive outputs: 32'h0000_0505 at pc 0, then 32'h0000_4505 at pc 2.
- Misaligned 32-bit: mem[0]={16'h0113, 16'h0505}, mem[4]={16'h4505, 16'h0041}:
  - out 32'h0000_0505 at pc 0.
  - out 32'h0041_0113 at pc 2; inst_valid low until the mem[4] response.
  - out 32'h0000_4505 at pc 6.
- Redirect to redirect_pc=32'h0000_0106 while a request is outstanding with latency 3:
  - The stale response is dropped (S_DISCARD).
  - The next imem_addr is 32'h0000_0104.
  - The first output is the upper halfword of that word, with inst_pc=32'h106.
- inst_ready=0 for 5 cycles with cnt=3 -> no imem_req, and inst_o/inst_pc stable. Raise inst_ready: outputs resume in order with no lost or duplicated halfwords.
- Redirect in the same cycle as imem_rvalid in S_WAIT -> the data is not appended, and state is S_FETCH the next cycle with imem_req=1 at the redirect word address.

Source files
------------

// File: rtl/ic_fetch_aligner.sv
// RV32IC fetch aligner: word-aligned instruction memory reads feed a 3-halfword buffer,
// from which one complete 16-bit or 32-bit instruction per cycle is presented with its PC.
module ic_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t      state_r, state_nx_s;
    logic [47:0] buf_r, buf_nx_s, buf_ac_s;
    logic [1:0]  cnt_r, cnt_nx_s, cnt_ac_s;
    logic [31:0] pc_r, pc_nx_s;
    logic [31:0] faddr_r, faddr_nx_s;
    logic        drop_lo_r, drop_lo_nx_s;

    logic [15:0] hw0_s;
    logic        is_comp_s;
    logic        inst_valid_s;
    logic        fire_s;
    logic [1:0]  consume_s;
    logic        req_s;
    logic [2:0]  cnt_sum_s;

    // Place the returned word (or only its upper halfword) right after the surviving halfwords.
    function automatic logic [47:0] append_hw(input logic [47:0] base, input logic [1:0] pos,
                                              input logic [31:0] data, input logic drop);
        logic [47:0] ins;
        ins = drop ? {32'h0000_0000, data[31:16]} : {16'h0000, data};
        case (pos)
            2'd0:    append_hw = ins;
            2'd1:    append_hw = {ins[31:0], base[15:0]};
            2'd2:    append_hw = {ins[15:0], base[31:0]};
            default: append_hw = base;
        endcase
    endfunction

    // Instruction assembly, consumption and request decision.
    always_comb begin
        hw0_s     = buf_r[15:0];
        is_comp_s = (hw0_s[1:0] != 2'b11);
        if (cnt_r == 2'd0) begin
            inst_valid_s = 1'b0;
        end else if (is_comp_s) begin
            inst_valid_s = 1'b1;
        end else begin
            inst_valid_s = (cnt_r >= 2'd2);
        end
        fire_s = inst_valid_s & inst_ready & ~redirect;
        if (fire_s) begin
            consume_s = is_comp_s ? 2'd1 : 2'd2;
        end else begin
            consume_s = 2'd0;
        end
        case (consume_s)
            2'd1:    buf_ac_s = {16'h0000, buf_r[47:16]};
            2'd2:    buf_ac_s = {32'h0000_0000, buf_r[47:32]};
            default: buf_ac_s = buf_r;
        endcase
        cnt_ac_s = cnt_r - consume_s;
        // Gated by rst_n so no request is visible while the block is held in reset.
        req_s = rst_n & (state_r == S_FETCH) & (cnt_ac_s <= 2'd1) & ~redirect;
    end

    assign imem_req   = req_s;
    assign imem_addr  = faddr_r;
    assign inst_valid = inst_valid_s;
    assign inst_pc    = pc_r;
    assign inst_o     = inst_valid_s ? (is_comp_s ? {16'h0000, hw0_s} : buf_r[31:0]) : 32'h0000_0000;

    // Next-state logic; redirect overrides everything.
    always_comb begin
        state_nx_s   = state_r;
        buf_nx_s     = buf_ac_s;
        cnt_nx_s     = cnt_ac_s;
        pc_nx_s      = pc_r + {29'd0, consume_s, 1'b0};
        faddr_nx_s   = faddr_r;
        drop_lo_nx_s = drop_lo_r;
        cnt_sum_s    = {1'b0, cnt_ac_s} + (drop_lo_r ? 3'd1 : 3'd2);
        if (redirect) begin
            buf_nx_s     = 48'h0;
            cnt_nx_s     = 2'd0;
            pc_nx_s      = redirect_pc & 32'hFFFF_FFFE;
            faddr_nx_s   = redirect_pc & 32'hFFFF_FFFC;
            drop_lo_nx_s = redirect_pc[1];
            // An outstanding response arriving now retires the request; otherwise it must be skipped later.
            case (state_r)
                S_FETCH:   state_nx_s = S_FETCH;
                S_WAIT:    state_nx_s = imem_rvalid ? S_FETCH : S_DISCARD;
                S_DISCARD: state_nx_s = imem_rvalid ? S_FETCH : S_DISCARD;
                default:   state_nx_s = S_FETCH;
            endcase
        end else begin
            case (state_r)
                S_FETCH: begin
                    if (req_s) begin
                        state_nx_s = S_WAIT;
                    end else begin
                        state_nx_s = S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        buf_nx_s     = append_hw(buf_ac_s, cnt_ac_s, imem_rdata, drop_lo_r);
                        cnt_nx_s     = (cnt_sum_s > 3'd3) ? 2'd3 : cnt_sum_s[1:0];
                        drop_lo_nx_s = 1'b0;
                        faddr_nx_s   = faddr_r + 32'd4;
                        state_nx_s   = S_FETCH;
                    end else begin
                        state_nx_s = S_WAIT;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid) begin
                        state_nx_s = S_FETCH;
                    end else begin
                        state_nx_s = S_DISCARD;
                    end
                end
                default: state_nx_s = S_FETCH;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_FETCH;
            buf_r     <= 48'h0;
            cnt_r     <= 2'd0;
            pc_r      <= RESET_PC;
            faddr_r   <= {RESET_PC[31:2], 2'b00};
            drop_lo_r <= RESET_PC[1];
        end else begin
            state_r   <= state_nx_s;
            buf_r     <= buf_nx_s;
            cnt_r     <= cnt_nx_s;
            pc_r      <= pc_nx_s;
            faddr_r   <= faddr_nx_s;
            drop_lo_r <= drop_lo_nx_s;
        end
    end

endmodule

// File: tb/tb_ic_fetch_aligner.sv
// Directed bench for ic_fetch_aligner with a simple variable-latency instruction memory.
module tb_ic_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int lat      = 1;
    int pend;
    logic [31:0] paddr;
    logic [31:0] mem [0:255];

    ic_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_o      (inst_o),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    // Memory responder: one outstanding read, answered 'lat' cycles after the request edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rvalid <= 1'b0;
            imem_rdata  <= 32'h0;
            pend        <= 0;
            paddr       <= 32'h0;
        end else begin
            imem_rvalid <= 1'b0;
            if (pend > 0) begin
                if (pend == 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem[paddr[9:2]];
                end
                pend <= pend - 1;
            end else if (imem_req) begin
                if (lat <= 1) begin
                    imem_rvalid <= 1'b1;
                    imem_rdata  <= mem[imem_addr[9:2]];
                end else begin
                    paddr <= imem_addr;
                    pend  <= lat - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
    endtask

    task automatic do_reset(input logic rdy);
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = rdy;
        repeat (2) next_cycle();
        check("rst_req",   {31'h0, imem_req},   32'h0);
        check("rst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_inst",  inst_o,              32'h0);
        check("rst_pc",    inst_pc,             32'h0);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        int n = 0;
        while (inst_valid !== 1'b1 && n < max_cyc) begin
            next_cycle();
            n++;
        end
        check(tag, {31'h0, inst_valid}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;

        // Aligned 32-bit instruction, latency 1
        fill_mem();
        mem[0] = 32'h0041_0113;
        lat = 1;
        do_reset(1'b1);
        check("t1_req0",  {31'h0, imem_req}, 32'h1);
        check("t1_addr0", imem_addr, 32'h0);
        next_cycle();
        check("t1_req1",   {31'h0, imem_req},   32'h0);
        check("t1_valid1", {31'h0, inst_valid}, 32'h0);
        next_cycle();
        check("t1_valid2", {31'h0, inst_valid}, 32'h1);
        check("t1_inst2",  inst_o,  32'h0041_0113);
        check("t1_pc2",    inst_pc, 32'h0);
        check("t1_req2",   {31'h0, imem_req}, 32'h1);
        check("t1_addr2",  imem_addr, 32'h4);

        // Two compressed instructions in one word
        fill_mem();
        mem[0] = 32'h4505_0505;
        do_reset(1'b1);
        repeat (2) next_cycle();
        check("t2_inst_a", inst_o,  32'h0000_0505);
        check("t2_pc_a",   inst_pc, 32'h0);
        check("t2_addr_a", imem_addr, 32'h4);
        next_cycle();
        check("t2_valid_b", {31'h0, inst_valid}, 32'h1);
        check("t2_inst_b",  inst_o,  32'h0000_4505);
        check("t2_pc_b",    inst_pc, 32'h2);

        // 32-bit instruction straddling a word boundary
        fill_mem();
        mem[0] = 32'h0113_0505;
        mem[1] = 32'h4505_0041;
        do_reset(1'b1);
        repeat (2) next_cycle();
        check("t3_inst_a", inst_o,  32'h0000_0505);
        check("t3_pc_a",   inst_pc, 32'h0);
        next_cycle();
        check("t3_split_invalid", {31'h0, inst_valid}, 32'h0);
        next_cycle();
        check("t3_valid_b", {31'h0, inst_valid}, 32'h1);
        check("t3_inst_b",  inst_o,  32'h0041_0113);
        check("t3_pc_b",    inst_pc, 32'h2);
        next_cycle();
        check("t3_inst_c", inst_o,  32'h0000_4505);
        check("t3_pc_c",   inst_pc, 32'h6);

        // Redirect while a latency-3 read is outstanding
        fill_mem();
        mem[0]  = 32'h1111_1111;
        mem[65] = 32'h4505_0001;
        lat = 3;
        do_reset(1'b1);
        check("t4_addr0", imem_addr, 32'h0);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0106;
        #1;
        check("t4_req_redir", {31'h0, imem_req}, 32'h0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("t4_req_disc2", {31'h0, imem_req}, 32'h0);
        next_cycle();
        check("t4_req_disc3", {31'h0, imem_req}, 32'h0);
        next_cycle();
        check("t4_req_new",    {31'h0, imem_req},   32'h1);
        check("t4_addr_new",   imem_addr,           32'h0000_0104);
        check("t4_valid_none", {31'h0, inst_valid}, 32'h0);
        wait_valid("t4_timeout", 20);
        check("t4_inst", inst_o,  32'h0000_4505);
        check("t4_pc",   inst_pc, 32'h0000_0106);

        // Downstream stall with a full buffer
        fill_mem();
        mem[0] = 32'h0505_1111;
        mem[1] = 32'h4505_0085;
        lat = 1;
        do_reset(1'b0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0002;
        #1;
        check("t5_req_redir", {31'h0, imem_req}, 32'h0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("t5_addr0", imem_addr, 32'h0);
        repeat (2) next_cycle();
        check("t5_req_cnt1", {31'h0, imem_req}, 32'h1);
        check("t5_addr4",    imem_addr, 32'h4);
        repeat (2) next_cycle();
        for (int i = 0; i < 5; i++) begin
            check("t5_stall_req",  {31'h0, imem_req}, 32'h0);
            check("t5_stall_inst", inst_o,  32'h0000_0505);
            check("t5_stall_pc",   inst_pc, 32'h2);
            next_cycle();
        end
        inst_ready = 1'b1;
        #1;
        check("t5_out_a", inst_o,  32'h0000_0505);
        check("t5_pc_a",  inst_pc, 32'h2);
        next_cycle();
        check("t5_out_b",  inst_o,  32'h0000_0085);
        check("t5_pc_b",   inst_pc, 32'h4);
        check("t5_addr_b", imem_addr, 32'h8);
        next_cycle();
        check("t5_out_c", inst_o,  32'h0000_4505);
        check("t5_pc_c",  inst_pc, 32'h6);

        // Redirect coinciding with the response
        fill_mem();
        mem[0] = 32'h1111_1111;
        mem[2] = 32'h4505_0505;
        do_reset(1'b1);
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0008;
        #1;
        check("t6_req_redir",   {31'h0, imem_req},   32'h0);
        check("t6_valid_redir", {31'h0, inst_valid}, 32'h0);
        next_cycle();
        redirect = 1'b0;
        #1;
        check("t6_req_after",   {31'h0, imem_req},   32'h1);
        check("t6_addr_after",  imem_addr,           32'h8);
        check("t6_valid_after", {31'h0, inst_valid}, 32'h0);
        wait_valid("t6_timeout", 20);
        check("t6_inst", inst_o,  32'h0000_0505);
        check("t6_pc",   inst_pc, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
